// File: rtl/atm_txn_controller.sv
// atm_txn_controller
//   Card/PIN/amount transaction sequencer for a cash dispenser.
//   The state, try counter, idle timer, latched amount and error flags are
//   all flops. Every output is decoded from those flops (Moore).
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   card_inserted    level, high while a card is present
//   pin_valid        strobe, PIN entry complete; pin_correct qualifies it
//   amt_valid        strobe, amount request present; amount qualifies it
//   balance          account balance, compared in CHECK_BAL
//   unlock           operator strobe releasing LOCKED
//   dispense_cash    high for the single DISPENSE cycle
//   dispense_amt     latched amount while dispensing, 0 otherwise
//   card_retained    high while LOCKED
//   err_valid        one-cycle error pulse; err_code 01 PIN, 10 timeout, 11 funds
//   state_o          current state encoding
module atm_txn_controller #(
    parameter int unsigned AMT_W       = 16,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             card_inserted,
    input  logic             pin_valid,
    input  logic             pin_correct,
    input  logic             amt_valid,
    input  logic [AMT_W-1:0] amount,
    input  logic [AMT_W-1:0] balance,
    input  logic             unlock,
    output logic             dispense_cash,
    output logic [AMT_W-1:0] dispense_amt,
    output logic             card_retained,
    output logic             err_valid,
    output logic [1:0]       err_code,
    output logic [2:0]       state_o
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);

    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ERR_PIN     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_FUNDS   = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_PIN  = 3'd1,
        WAIT_AMT  = 3'd2,
        CHECK_BAL = 3'd3,
        DISPENSE  = 3'd4,
        LOCKED    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [TRY_W-1:0]   try_q, try_d, try_inc;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [AMT_W-1:0]   amt_q, amt_d;
    logic               err_valid_q, err_valid_d;
    logic [1:0]         err_code_q, err_code_d;

    always_comb begin
        state_d     = state_q;
        try_d       = try_q;
        timer_d     = timer_q;
        amt_d       = amt_q;
        err_valid_d = 1'b0;
        err_code_d  = 2'b00;
        try_inc     = try_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (card_inserted) begin
                    state_d = WAIT_PIN;
                    try_d   = '0;
                end
            end
            // Priority in both wait states: card removal, then strobe, then timeout.
            WAIT_PIN: begin
                if (!card_inserted) begin
                    state_d = IDLE;
                end else if (pin_valid) begin
                    timer_d = '0;
                    if (pin_correct) begin
                        state_d = WAIT_AMT;
                    end else begin
                        try_d       = try_inc;
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_PIN;
                        if (try_inc == TRY_LIMIT) begin
                            state_d = LOCKED;
                        end
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d     = IDLE;
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_AMT: begin
                if (!card_inserted) begin
                    state_d = IDLE;
                end else if (amt_valid) begin
                    amt_d   = amount;
                    state_d = CHECK_BAL;
                end else if (timer_q == TMR_LAST) begin
                    state_d     = IDLE;
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CHECK_BAL: begin
                if (!card_inserted) begin
                    state_d = IDLE;
                end else if ((amt_q != '0) && (amt_q <= balance)) begin
                    state_d = DISPENSE;
                end else begin
                    state_d     = IDLE;
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_FUNDS;
                end
            end
            DISPENSE: begin
                state_d = IDLE;
            end
            LOCKED: begin
                if (unlock) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Any state change restarts the idle timer.
        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            try_q       <= '0;
            timer_q     <= '0;
            amt_q       <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            try_q       <= try_d;
            timer_q     <= timer_d;
            amt_q       <= amt_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign dispense_cash = (state_q == DISPENSE);
    assign dispense_amt  = (state_q == DISPENSE) ? amt_q : '0;
    assign card_retained = (state_q == LOCKED);
    assign err_valid     = err_valid_q;
    assign err_code      = err_code_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_atm_txn_controller.sv
// tb_atm_txn_controller
//   Directed bench: a table of per-cycle {inputs, expected outputs} records,
//   followed by hand-written timeout and asynchronous-reset sequences.
module tb_atm_txn_controller;

    logic        clk;
    logic        rst_n;
    logic        card_inserted;
    logic        pin_valid;
    logic        pin_correct;
    logic        amt_valid;
    logic [15:0] amount;
    logic [15:0] balance;
    logic        unlock;
    logic        dispense_cash;
    logic [15:0] dispense_amt;
    logic        card_retained;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;

    atm_txn_controller #(
        .AMT_W(16),
        .MAX_TRIES(3),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .card_inserted(card_inserted),
        .pin_valid(pin_valid),
        .pin_correct(pin_correct),
        .amt_valid(amt_valid),
        .amount(amount),
        .balance(balance),
        .unlock(unlock),
        .dispense_cash(dispense_cash),
        .dispense_amt(dispense_amt),
        .card_retained(card_retained),
        .err_valid(err_valid),
        .err_code(err_code),
        .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        card;
        logic        pv;
        logic        pc;
        logic        av;
        logic [15:0] amt;
        logic [15:0] bal;
        logic        unl;
        logic [2:0]  st;
        logic        disp;
        logic [15:0] damt;
        logic        ret;
        logic        ev;
        logic [1:0]  ec;
    } vec_t;

    function automatic vec_t mk(logic card, logic pv, logic pc, logic av,
                                logic [15:0] amt, logic [15:0] bal, logic unl,
                                logic [2:0] st, logic disp, logic [15:0] damt,
                                logic ret, logic ev, logic [1:0] ec);
        vec_t v;
        v.card = card; v.pv = pv; v.pc = pc; v.av = av;
        v.amt = amt; v.bal = bal; v.unl = unl;
        v.st = st; v.disp = disp; v.damt = damt;
        v.ret = ret; v.ev = ev; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic disp,
                           input logic [15:0] damt, input logic ret,
                           input logic ev, input logic [1:0] ec);
        chk({tag, ".state"},  16'(state_o),       16'(st));
        chk({tag, ".disp"},   16'(dispense_cash), 16'(disp));
        chk({tag, ".damt"},   dispense_amt,       damt);
        chk({tag, ".ret"},    16'(card_retained), 16'(ret));
        chk({tag, ".errv"},   16'(err_valid),     16'(ev));
        chk({tag, ".errc"},   16'(err_code),      16'(ec));
    endtask

    // Drive inputs, take one rising edge, settle just after it.
    task automatic drive(input logic card, input logic pv, input logic pc, input logic av,
                         input logic [15:0] amt, input logic [15:0] bal, input logic unl);
        card_inserted = card; pin_valid = pv; pin_correct = pc; amt_valid = av;
        amount = amt; balance = bal; unlock = unl;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [28];

    initial begin
        // state codes: 0 IDLE 1 WAIT_PIN 2 WAIT_AMT 3 CHECK_BAL 4 DISPENSE 5 LOCKED
        // happy path, balance equal to amount
        tbl[0]  = mk(1,0,0,0,  0,  0,0, 1,0,  0,0,0,2'b00);
        tbl[1]  = mk(1,1,1,0,  0,  0,0, 2,0,  0,0,0,2'b00);
        tbl[2]  = mk(1,0,0,1,100,100,0, 3,0,  0,0,0,2'b00);
        tbl[3]  = mk(1,0,0,0,  0,100,0, 4,1,100,0,0,2'b00);
        tbl[4]  = mk(1,0,0,0,  0,100,0, 0,0,  0,0,0,2'b00);
        tbl[5]  = mk(1,0,0,0,  0,  0,0, 1,0,  0,0,0,2'b00);
        // lockout after three wrong PINs, stray strobes ignored while locked
        tbl[6]  = mk(1,1,0,0,  0,  0,0, 1,0,  0,0,1,2'b01);
        tbl[7]  = mk(1,0,0,0,  0,  0,0, 1,0,  0,0,0,2'b00);
        tbl[8]  = mk(1,1,0,0,  0,  0,0, 1,0,  0,0,1,2'b01);
        tbl[9]  = mk(1,1,0,0,  0,  0,0, 5,0,  0,1,1,2'b01);
        tbl[10] = mk(1,1,1,1, 50,100,0, 5,0,  0,1,0,2'b00);
        tbl[11] = mk(0,0,0,0,  0,  0,0, 5,0,  0,1,0,2'b00);
        tbl[12] = mk(0,0,0,0,  0,  0,1, 0,0,  0,0,0,2'b00);
        // insufficient funds
        tbl[13] = mk(1,0,0,0,  0,  0,0, 1,0,  0,0,0,2'b00);
        tbl[14] = mk(1,1,1,0,  0,  0,0, 2,0,  0,0,0,2'b00);
        tbl[15] = mk(1,0,0,1,101,100,0, 3,0,  0,0,0,2'b00);
        tbl[16] = mk(1,0,0,0,  0,100,0, 0,0,  0,0,1,2'b11);
        // zero amount
        tbl[17] = mk(1,0,0,0,  0,  0,0, 1,0,  0,0,0,2'b00);
        tbl[18] = mk(1,1,1,0,  0,  0,0, 2,0,  0,0,0,2'b00);
        tbl[19] = mk(1,0,0,1,  0,100,0, 3,0,  0,0,0,2'b00);
        tbl[20] = mk(1,0,0,0,  0,100,0, 0,0,  0,0,1,2'b11);
        // card pulled in the same cycle as a correct PIN
        tbl[21] = mk(1,0,0,0,  0,  0,0, 1,0,  0,0,0,2'b00);
        tbl[22] = mk(0,1,1,0,  0,  0,0, 0,0,  0,0,0,2'b00);
        // strobes in IDLE with no card do nothing
        tbl[23] = mk(0,1,1,1, 77,100,0, 0,0,  0,0,0,2'b00);
        // card pulled during CHECK_BAL: no dispense, no error
        tbl[24] = mk(1,0,0,0,  0,  0,0, 1,0,  0,0,0,2'b00);
        tbl[25] = mk(1,1,1,0,  0,  0,0, 2,0,  0,0,0,2'b00);
        tbl[26] = mk(1,0,0,1, 50,100,0, 3,0,  0,0,0,2'b00);
        tbl[27] = mk(0,0,0,0,  0,100,0, 0,0,  0,0,0,2'b00);

        rst_n = 1'b0;
        card_inserted = 0; pin_valid = 0; pin_correct = 0; amt_valid = 0;
        amount = '0; balance = '0; unlock = 0;
        #1;
        chk_all("reset", 3'd0, 1'b0, 16'd0, 1'b0, 1'b0, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].card, tbl[i].pv, tbl[i].pc, tbl[i].av,
                  tbl[i].amt, tbl[i].bal, tbl[i].unl);
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].disp, tbl[i].damt,
                    tbl[i].ret, tbl[i].ev, tbl[i].ec);
        end

        // Timeout in WAIT_AMT: 15 idle cycles stay, the 16th aborts with err 10.
        drive(1,0,0,0,0,0,0);
        drive(1,1,1,0,0,0,0);
        chk("to.enter", 16'(state_o), 16'd2);
        for (int c = 1; c <= 15; c++) drive(1,0,0,0,0,0,0);
        chk("to.hold15.state", 16'(state_o), 16'd2);
        chk("to.hold15.errv",  16'(err_valid), 16'd0);
        drive(1,0,0,0,0,0,0);
        chk_all("to.expire", 3'd0, 1'b0, 16'd0, 1'b0, 1'b1, 2'b10);

        // Strobe on the 15th waiting cycle is still accepted.
        drive(1,0,0,0,0,0,0);
        drive(1,1,1,0,0,0,0);
        for (int c = 1; c <= 14; c++) drive(1,0,0,0,0,0,0);
        drive(1,0,0,1,16'd40,16'd0,0);
        chk_all("to.late", 3'd3, 1'b0, 16'd0, 1'b0, 1'b0, 2'b00);
        drive(1,0,0,0,0,16'd40,0);
        chk_all("to.late.disp", 3'd4, 1'b1, 16'd40, 1'b0, 1'b0, 2'b00);

        // Asynchronous reset in the middle of DISPENSE.
        drive(1,0,0,0,0,0,0);
        drive(1,0,0,0,0,0,0);
        drive(1,1,1,0,0,0,0);
        drive(1,0,0,1,16'd7,16'd9,0);
        drive(1,0,0,0,0,16'd9,0);
        chk("rd.pre", 16'(dispense_cash), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_all("rst.disp", 3'd0, 1'b0, 16'd0, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1,0,0,0,0,0,0);
        chk("rst.first_edge", 16'(state_o), 16'd1);

        // Asynchronous reset while LOCKED.
        drive(1,1,0,0,0,0,0);
        drive(1,1,0,0,0,0,0);
        drive(1,1,0,0,0,0,0);
        chk("rl.pre", 16'(card_retained), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_all("rst.lock", 3'd0, 1'b0, 16'd0, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0,0,0,0,0,0,0);
        chk("rst.lock.idle", 16'(state_o), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
